// File: rtl/vector_seq_control_pkg.sv
// Shared encodings for the vector sequencer: instruction classes, ALU op codes,
// sequencer states and the packed control word handed from decode to the sequencer.
package vector_seq_control_pkg;

  typedef enum logic [1:0] {
    ITYPE_MEM  = 2'b00,
    ITYPE_DATA = 2'b01,
    ITYPE_CTRL = 2'b10,
    ITYPE_VEC  = 2'b11
  } itype_e;

  localparam logic [2:0] ALUS_ADD = 3'b000;
  localparam logic [2:0] ALUS_SUB = 3'b001;
  localparam logic [2:0] ALUS_AND = 3'b010;
  localparam logic [2:0] ALUS_OR  = 3'b011;
  localparam logic [2:0] ALUS_SLT = 3'b111;

  localparam logic [2:0] ALUV_ADD = 3'b000;
  localparam logic [2:0] ALUV_MUL = 3'b010;
  localparam logic [2:0] ALUV_OP3 = 3'b011;
  localparam logic [2:0] ALUV_OP4 = 3'b100;
  localparam logic [2:0] ALUV_OP5 = 3'b101;
  localparam logic [2:0] ALUV_OP6 = 3'b110;

  localparam logic [1:0] IMM_BRANCH = 2'b00;
  localparam logic [1:0] IMM_I      = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    VECTOR,
    ILLEGAL
  } state_e;

  typedef struct packed {
    logic       Brinco;
    logic       Equal;
    logic       GreaterEqual;
    logic       LessEqual;
    logic       MemRead;
    logic       MemWrite;
    logic       WriteVec;
    logic       MemToReg;
    logic       ALUSrc;
    logic       RegWriteS;
    logic       RegWriteV;
    logic       AluData;
    logic [2:0] ALUOpS;
    logic [2:0] ALUOpV;
    logic [1:0] ImmSrc;
  } ctl_word_t;

  // Width of the beat counter; a single-beat configuration still gets one bit.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vector_ctl_decode.sv
// Combinational instruction decode: maps type/func fields to a control word,
// flags undefined encodings and vector-class (multi-beat) instructions.
module vector_ctl_decode
  import vector_seq_control_pkg::*;
(
  input  logic [1:0] instruction_type_i,
  input  logic [4:0] func_i,
  output ctl_word_t  ctl_o,
  output logic       illegal_o,
  output logic       is_vector_o
);

  ctl_word_t ctl;
  logic      bad;

  always_comb begin
    ctl         = '0;
    bad         = 1'b0;
    is_vector_o = 1'b0;
    unique case (itype_e'(instruction_type_i))
      ITYPE_MEM: begin
        ctl.ALUSrc  = 1'b1;
        ctl.ImmSrc  = IMM_I;
        is_vector_o = func_i[4];
        unique case (func_i[4:3])
          2'b00: begin
            ctl.MemRead   = 1'b1;
            ctl.RegWriteS = 1'b1;
            ctl.MemToReg  = 1'b1;
          end
          2'b01: ctl.MemWrite = 1'b1;
          2'b10: begin
            ctl.MemRead   = 1'b1;
            ctl.RegWriteV = 1'b1;
            ctl.MemToReg  = 1'b1;
          end
          default: begin
            ctl.MemWrite = 1'b1;
            ctl.WriteVec = 1'b1;
          end
        endcase
      end
      ITYPE_DATA: begin
        ctl.RegWriteS = 1'b1;
        if (func_i[4]) begin
          ctl.ALUOpS = func_i[3:1];
          ctl.ALUSrc = 1'b1;
          ctl.ImmSrc = IMM_I;
        end else begin
          case (func_i)
            5'b00000: ctl.ALUOpS = ALUS_ADD;
            5'b00001: ctl.ALUOpS = ALUS_SUB;
            5'b00010: ctl.ALUOpS = ALUS_AND;
            5'b00011: ctl.ALUOpS = ALUS_OR;
            5'b01011: ctl.ALUOpS = ALUS_SLT;
            default:  bad = 1'b1;
          endcase
        end
      end
      ITYPE_CTRL: begin
        ctl.ALUOpS = ALUS_SUB;
        ctl.ImmSrc = IMM_BRANCH;
        unique case (func_i[4:3])
          2'b00:   ctl.Brinco       = 1'b1;
          2'b01:   ctl.LessEqual    = 1'b1;
          2'b10:   ctl.Equal        = 1'b1;
          default: ctl.GreaterEqual = 1'b1;
        endcase
      end
      default: begin
        is_vector_o   = 1'b1;
        ctl.AluData   = 1'b1;
        ctl.RegWriteV = 1'b1;
        // func[0] only selects within the 00/01 groups; the upper groups ignore it.
        unique case (func_i[4:3])
          2'b00: begin
            case (func_i[2:0])
              3'b000:  ctl.ALUOpV = ALUV_ADD;
              3'b001:  ctl.ALUOpV = ALUV_MUL;
              default: bad = 1'b1;
            endcase
          end
          2'b01: begin
            case (func_i[2:0])
              3'b010:  ctl.ALUOpV = ALUV_ADD;
              3'b011:  ctl.ALUOpV = ALUV_MUL;
              default: bad = 1'b1;
            endcase
          end
          2'b10: begin
            case (func_i[2:1])
              2'b00:   ctl.ALUOpV = ALUV_OP3;
              2'b01:   ctl.ALUOpV = ALUV_OP4;
              2'b10:   ctl.ALUOpV = ALUV_OP5;
              default: bad = 1'b1;
            endcase
          end
          default: begin
            if (func_i[2:1] == 2'b00) ctl.ALUOpV = ALUV_OP6;
            else                      bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign ctl_o     = bad ? '0 : ctl;
  assign illegal_o = bad;

endmodule

// File: rtl/vector_seq_control.sv
// Instruction sequencer: registers the decoded control word on accept and replays
// it for one beat (scalar) or BEATS beats (vector), honouring downstream stall.
module vector_seq_control
  import vector_seq_control_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned VLEN  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 instr_valid,
  output logic                                 instr_ready,
  input  logic [1:0]                           instruction_type,
  input  logic [4:0]                           func,
  input  logic                                 stall,
  output logic                                 ctl_valid,
  output logic                                 Brinco,
  output logic                                 Equal,
  output logic                                 GreaterEqual,
  output logic                                 LessEqual,
  output logic                                 MemRead,
  output logic                                 MemWrite,
  output logic                                 WriteVec,
  output logic                                 MemToReg,
  output logic                                 ALUSrc,
  output logic                                 RegWriteS,
  output logic                                 RegWriteV,
  output logic                                 AluData,
  output logic [2:0]                           ALUOpS,
  output logic [2:0]                           ALUOpV,
  output logic [1:0]                           ImmSrc,
  output logic [beat_w(VLEN/LANES)-1:0]        beat_idx,
  output logic                                 last_beat,
  output logic                                 busy,
  output logic                                 illegal
);

  localparam int unsigned BEATS = VLEN / LANES;
  localparam int unsigned BW    = beat_w(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  ctl_word_t     ctl_q, ctl_d;

  ctl_word_t     dec_ctl;
  logic          dec_illegal;
  logic          dec_is_vector;
  logic          accept;
  ctl_word_t     ctl_out;

  vector_ctl_decode u_decode (
    .instruction_type_i (instruction_type),
    .func_i             (func),
    .ctl_o              (dec_ctl),
    .illegal_o          (dec_illegal),
    .is_vector_o        (dec_is_vector)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    ctl_valid   = (state_q == SINGLE) || (state_q == VECTOR);
    last_beat   = (state_q == SINGLE) || ((state_q == VECTOR) && (beat_q == LAST_BEAT));
    busy        = (state_q != IDLE);
    illegal     = (state_q == ILLEGAL);
    // Held low during reset so every output reads 0 until release.
    instr_ready = !rst && ((state_q == IDLE) || (last_beat && !stall));
    accept      = instr_valid && instr_ready;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ctl_d   = ctl_q;
    if (accept) begin
      ctl_d  = dec_ctl;
      beat_d = '0;
      if (dec_illegal)        state_d = ILLEGAL;
      else if (dec_is_vector) state_d = VECTOR;
      else                    state_d = SINGLE;
    end else begin
      unique case (state_q)
        SINGLE: if (!stall) state_d = IDLE;
        VECTOR: begin
          if (!stall) begin
            if (beat_q == LAST_BEAT) begin
              state_d = IDLE;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        ILLEGAL: state_d = IDLE;
        default: ;
      endcase
    end
  end

  assign ctl_out      = ctl_valid ? ctl_q : '0;
  assign Brinco       = ctl_out.Brinco;
  assign Equal        = ctl_out.Equal;
  assign GreaterEqual = ctl_out.GreaterEqual;
  assign LessEqual    = ctl_out.LessEqual;
  assign MemRead      = ctl_out.MemRead;
  assign MemWrite     = ctl_out.MemWrite;
  assign WriteVec     = ctl_out.WriteVec;
  assign MemToReg     = ctl_out.MemToReg;
  assign ALUSrc       = ctl_out.ALUSrc;
  assign RegWriteS    = ctl_out.RegWriteS;
  assign RegWriteV    = ctl_out.RegWriteV;
  assign AluData      = ctl_out.AluData;
  assign ALUOpS       = ctl_out.ALUOpS;
  assign ALUOpV       = ctl_out.ALUOpV;
  assign ImmSrc       = ctl_out.ImmSrc;
  assign beat_idx     = beat_q;

endmodule

// File: tb/tb_vector_seq_control.sv
// Directed bench for vector_seq_control (LANES=4, VLEN=16 -> 4 beats).
module tb_vector_seq_control;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instruction_type;
  logic [4:0] func;
  logic       stall;
  logic       ctl_valid;
  logic       Brinco, Equal, GreaterEqual, LessEqual;
  logic       MemRead, MemWrite, WriteVec, MemToReg, ALUSrc, RegWriteS, RegWriteV, AluData;
  logic [2:0] ALUOpS, ALUOpV;
  logic [1:0] ImmSrc;
  logic [1:0] beat_idx;
  logic       last_beat, busy, illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  vector_seq_control #(.LANES(4), .VLEN(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction_type (instruction_type),
    .func             (func),
    .stall            (stall),
    .ctl_valid        (ctl_valid),
    .Brinco           (Brinco),
    .Equal            (Equal),
    .GreaterEqual     (GreaterEqual),
    .LessEqual        (LessEqual),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .WriteVec         (WriteVec),
    .MemToReg         (MemToReg),
    .ALUSrc           (ALUSrc),
    .RegWriteS        (RegWriteS),
    .RegWriteV        (RegWriteV),
    .AluData          (AluData),
    .ALUOpS           (ALUOpS),
    .ALUOpV           (ALUOpV),
    .ImmSrc           (ImmSrc),
    .beat_idx         (beat_idx),
    .last_beat        (last_beat),
    .busy             (busy),
    .illegal          (illegal)
  );

  // en bits: Brinco Equal GE LE MemRead MemWrite WriteVec MemToReg ALUSrc RegWriteS RegWriteV AluData
  logic [11:0] en;
  logic [4:0]  st;
  assign en = {Brinco, Equal, GreaterEqual, LessEqual, MemRead, MemWrite, WriteVec,
               MemToReg, ALUSrc, RegWriteS, RegWriteV, AluData};
  // st bits: ctl_valid last_beat busy illegal instr_ready
  assign st = {ctl_valid, last_beat, busy, illegal, instr_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] f);
    instr_valid      = 1'b1;
    instruction_type = t;
    func             = f;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction_type = 2'b00; func = 5'b00000; stall = 1'b0;
    #2;
    check("rst_status", 32'(st), 32'h00);
    check("rst_en", 32'(en), 32'h000);
    check("rst_beat", 32'(beat_idx), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle_status", 32'(st), 32'h01);

    // scalar add: one beat, one cycle after accept
    issue(2'b01, 5'b00000);
    step(); instr_valid = 1'b0;
    check("add_status", 32'(st), 32'h1D);
    check("add_en", 32'(en), 32'h004);
    check("add_aluops", 32'(ALUOpS), 32'h0);
    step();
    check("add_done", 32'(st), 32'h01);
    check("add_done_en", 32'(en), 32'h000);

    // data immediate: func 11010 -> ALUOpS 101, ALUSrc, ImmSrc 10
    issue(2'b01, 5'b11010);
    step(); instr_valid = 1'b0;
    check("imm_en", 32'(en), 32'h00C);
    check("imm_aluops", 32'(ALUOpS), 32'h5);
    check("imm_immsrc", 32'(ImmSrc), 32'h2);

    // slt: 01011 -> 111
    issue(2'b01, 5'b01011);
    step(); instr_valid = 1'b0;
    check("slt_aluops", 32'(ALUOpS), 32'h7);
    check("slt_en", 32'(en), 32'h004);

    // branch Equal: func[4:3]=10
    issue(2'b10, 5'b10000);
    step(); instr_valid = 1'b0;
    check("beq_en", 32'(en), 32'h400);
    check("beq_aluops", 32'(ALUOpS), 32'h1);
    check("beq_status", 32'(st), 32'h1D);
    step();
    check("beq_done", 32'(st), 32'h01);

    // vector mul with stall on beat 2 for 3 cycles
    issue(2'b11, 5'b00001);
    step(); instr_valid = 1'b0;
    check("vmul_b0_status", 32'(st), 32'h14);
    check("vmul_b0_beat", 32'(beat_idx), 32'h0);
    check("vmul_b0_aluopv", 32'(ALUOpV), 32'h2);
    check("vmul_b0_en", 32'(en), 32'h003);
    step();
    check("vmul_b1_beat", 32'(beat_idx), 32'h1);
    check("vmul_b1_status", 32'(st), 32'h14);
    step();
    check("vmul_b2_beat", 32'(beat_idx), 32'h2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_beat", 32'(beat_idx), 32'h2);
      check("stall_status", 32'(st), 32'h14);
      check("stall_aluopv", 32'(ALUOpV), 32'h2);
      check("stall_en", 32'(en), 32'h003);
    end
    stall = 1'b0;
    step();
    check("vmul_b3_beat", 32'(beat_idx), 32'h3);
    check("vmul_b3_status", 32'(st), 32'h1D);
    stall = 1'b1;
    #1;
    check("vmul_b3_stall_ready", 32'(st), 32'h1C);
    step();
    check("vmul_b3_held", 32'(beat_idx), 32'h3);
    stall = 1'b0;
    step();
    check("vmul_done", 32'(st), 32'h01);
    check("vmul_done_beat", 32'(beat_idx), 32'h0);

    // back-to-back: vector store then scalar load held valid
    issue(2'b00, 5'b11000);
    step();
    check("vst_b0_en", 32'(en), 32'h068);
    check("vst_b0_immsrc", 32'(ImmSrc), 32'h2);
    issue(2'b00, 5'b00000);
    check("vst_b0_status", 32'(st), 32'h14);
    step();
    check("vst_b1_beat", 32'(beat_idx), 32'h1);
    check("vst_b1_en", 32'(en), 32'h068);
    step(); step();
    check("vst_b3_beat", 32'(beat_idx), 32'h3);
    check("vst_b3_status", 32'(st), 32'h1D);
    step(); instr_valid = 1'b0;
    check("ld_status", 32'(st), 32'h1D);
    check("ld_en", 32'(en), 32'h09C);
    check("ld_beat", 32'(beat_idx), 32'h0);
    step();
    check("ld_done", 32'(st), 32'h01);

    // illegal scalar encoding
    issue(2'b01, 5'b00101);
    step(); instr_valid = 1'b0;
    check("ill_status", 32'(st), 32'h06);
    check("ill_en", 32'(en), 32'h000);
    step();
    check("ill_done", 32'(st), 32'h01);

    // illegal vector encoding
    issue(2'b11, 5'b00010);
    step(); instr_valid = 1'b0;
    check("vill_status", 32'(st), 32'h06);
    check("vill_en", 32'(en), 32'h000);
    step();

    // asynchronous reset in the middle of a vector add
    issue(2'b11, 5'b00000);
    step(); instr_valid = 1'b0;
    step();
    check("vadd_b1_beat", 32'(beat_idx), 32'h1);
    check("vadd_b1_en", 32'(en), 32'h003);
    #2 rst = 1'b1;
    #1;
    check("arst_status", 32'(st), 32'h00);
    check("arst_en", 32'(en), 32'h000);
    check("arst_beat", 32'(beat_idx), 32'h0);
    step();
    check("arst_hold", 32'(st), 32'h00);
    rst = 1'b0;
    #1;
    check("arst_release", 32'(st), 32'h01);
    step();
    check("arst_no_resid", 32'(st), 32'h01);
    check("arst_no_resid_beat", 32'(beat_idx), 32'h0);
    step();
    check("arst_no_resid2", 32'(st), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
